// File: rtl/booth_radix4_mult.sv
// -----------------------------------------------------------------------------
// booth_radix4_mult
//
// Sequential radix-4 Booth multiplier. It retires one Booth digit per clock,
// so every operation takes a fixed N/2+1 RUN cycles, whatever the operand
// values.
//
// Handshake: a request is start=1 while ready=1. It is accepted on that rising
// edge, and signed_mode, multiplicand and multiplier are captured on the same
// edge. start is ignored while busy=1 or done=1; it is neither queued nor
// remembered. done pulses for exactly one cycle. product is then valid and
// holds until the next completion.
//
// Ports
//   clk          : clock; all state updates on the rising edge
//   rst          : synchronous active-high reset
//   start        : request a multiplication (sampled only while ready=1)
//   signed_mode  : 1 = two's-complement operands, 0 = unsigned
//   multiplicand : operand M (N bits)
//   multiplier   : operand Q (N bits)
//   ready        : high in IDLE
//   busy         : high in RUN
//   done         : high for the single DONE cycle
//   product      : 2N-bit result of the last completed operation
//   dbg_state    : current FSM state encoding (IDLE=0, RUN=1, DONE=2)
// -----------------------------------------------------------------------------
module booth_radix4_mult #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic [1:0]     dbg_state
);

  // Operands are widened to N+2 bits. A zero-extended unsigned operand is
  // then a non-negative signed value, so one signed Booth datapath serves
  // both modes. N/2+1 digits cover all N+2 multiplier bits.
  localparam int OW = N + 2;
  // The accumulator carries two guard bits above the operand width so that
  // +/-2M never overflows.
  localparam int AW = N + 4;
  localparam int CW = $clog2(N / 2 + 2);
  localparam logic [CW-1:0] DIGITS = CW'(N / 2 + 1);
  localparam logic [CW-1:0] LAST   = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [OW-1:0]     m_q, m_d;
  logic [OW-1:0]     q_q, q_d;
  logic              qm1_q, qm1_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*N-1:0]    product_q, product_d;

  // Booth step signals
  logic [AW-1:0]     m_sx;
  logic [AW-1:0]     addend;
  logic [AW-1:0]     sum;
  logic [2:0]        triplet;
  logic [AW+OW:0]    shifted;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      m_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One Booth digit: choose the addend from {Q[1],Q[0],Q[-1]}, add it to the
  // accumulator, then arithmetic-shift {acc, Q, Q[-1]} right by two.
  // ---------------------------------------------------------------------------
  always_comb begin
    m_sx    = {{2{m_q[OW-1]}}, m_q};
    triplet = {q_q[1], q_q[0], qm1_q};
    addend  = '0;
    case (triplet)
      3'b001, 3'b010: addend = m_sx;
      3'b011:         addend = m_sx << 1;
      3'b100:         addend = {AW{1'b0}} - (m_sx << 1);
      3'b101, 3'b110: addend = {AW{1'b0}} - m_sx;
      default:        addend = '0;
    endcase
    sum     = acc_q + addend;
    shifted = $signed({sum, q_q, qm1_q}) >>> 2;
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_d     = acc_q;
    m_d       = m_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d   = signed_mode ? {{2{multiplicand[N-1]}}, multiplicand}
                              : {2'b00, multiplicand};
          q_d   = signed_mode ? {{2{multiplier[N-1]}}, multiplier}
                              : {2'b00, multiplier};
          acc_d = '0;
          qm1_d = 1'b0;
          cnt_d = DIGITS;
        end
      end
      RUN: begin
        acc_d = shifted[AW+OW:OW+1];
        q_d   = shifted[OW:1];
        qm1_d = shifted[0];
        cnt_d = cnt_q - LAST;
        // After the final shift, {acc, Q} holds the full product. Its low 2N
        // bits are the result in either mode.
        if (cnt_q == LAST) product_d = shifted[2*N:1];
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only
  // ---------------------------------------------------------------------------
  assign ready     = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign product   = product_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// -----------------------------------------------------------------------------
// tb_booth_radix4_mult
//
// Bench for booth_radix4_mult with N=8. The reference model works from the
// externally visible rules only:
//   - the exact product, computed with integer arithmetic;
//   - the timing window: busy for 5 cycles after the accept edge, done on the
//     5th edge after it, ready otherwise;
//   - product holds its value between completions.
// A single compare process checks the DUT against this model on every cycle.
// Directed cases also carry hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_booth_radix4_mult;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signed_mode;
  logic [N-1:0] mcand;
  logic [N-1:0] mplier;
  logic         ready;
  logic         busy;
  logic         done;
  logic [2*N-1:0] product;
  logic [1:0]   dbg_state;

  booth_radix4_mult #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .ready        (ready),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .dbg_state    (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int done_cnt = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] ref_mul(input logic mode, input logic [7:0] a,
                                          input logic [7:0] b);
    int x;
    int y;
    int p;
    x = mode ? int'($signed(a)) : int'({24'd0, a});
    y = mode ? int'($signed(b)) : int'({24'd0, b});
    p = x * y;
    return p[15:0];
  endfunction

  logic [15:0] exp_q[$];
  int          cyc      = 0;
  int          m_acc    = 0;
  bit          m_active = 1'b0;
  logic [15:0] m_prod   = 16'h0000;

  // The model samples the inputs on the active edge. The bench only changes
  // the inputs on falling edges.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_active = 1'b0;
      m_prod   = 16'h0000;
      exp_q.delete();
    end else begin
      if (m_active && (cyc == m_acc + 5) && (exp_q.size() > 0))
        m_prod = exp_q.pop_front();
      if ((!m_active || (cyc - m_acc >= 7)) && start) begin
        m_active = 1'b1;
        m_acc    = cyc;
        exp_q.push_back(ref_mul(signed_mode, mcand, mplier));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process (on the falling edge, away from the active edge)
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    int  j;
    bit  e_busy;
    bit  e_done;
    if (done === 1'b1) done_cnt++;
    if (chk_en) begin
      j      = cyc - m_acc;
      e_busy = m_active && (j >= 0) && (j <= 4);
      e_done = m_active && (j == 5);
      check1("ready", ready, !e_busy && !e_done);
      check1("busy", busy, e_busy);
      check1("done", done, e_done);
      check16("product", product, m_prod);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic wait_ready();
    int t;
    t = 0;
    while (ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (ready !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_ready: ready=%b after %0d cycles, required 1", ready, t);
    end
  endtask

  // Call on a falling edge with ready=1; returns on the falling edge right
  // after the accept edge and reports that edge number.
  task automatic issue(input logic mode, input logic [7:0] a, input logic [7:0] b,
                       output int acc_c);
    signed_mode = mode;
    mcand       = a;
    mplier      = b;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc_c = cyc;
  endtask

  task automatic directed(input string name, input logic mode, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] exp);
    int acc_c;
    int t;
    wait_ready();
    issue(mode, a, b, acc_c);
    t = 0;
    while (done !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check_int({name, "_latency"}, cyc - acc_c, 5);
    check16({name, "_product"}, product, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int acc_c;
    int base;
    rst         = 1'b1;
    start       = 1'b0;
    signed_mode = 1'b0;
    mcand       = '0;
    mplier      = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check1("rst_ready", ready, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check16("rst_product", product, 16'h0000);

    // Directed products
    directed("s_m128_sq", 1'b1, 8'h80, 8'h80, 16'h4000);
    directed("u_ff_ff",   1'b0, 8'hFF, 8'hFF, 16'hFE01);
    directed("s_ff_ff",   1'b1, 8'hFF, 8'hFF, 16'h0001);
    directed("s_7f_ff",   1'b1, 8'h7F, 8'hFF, 16'hFF81);
    directed("s_03_05",   1'b1, 8'h03, 8'h05, 16'h000F);

    // start held high with operands scrambled every cycle: -100 x 55
    wait_ready();
    base        = done_cnt;
    signed_mode = 1'b1;
    mcand       = 8'h9C;
    mplier      = 8'h37;
    start       = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      check1("robust_ready_low", ready, 1'b0);
      signed_mode = 1'($urandom_range(0, 1));
      mcand       = 8'($urandom_range(0, 255));
      mplier      = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    start = 1'b0;
    check_int("robust_done_pulses", done_cnt - base, 1);
    check16("robust_product", product, 16'hEA84);

    // Reset during the third RUN cycle
    wait_ready();
    base = done_cnt;
    issue(1'b0, 8'hA5, 8'h5A, acc_c);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check1("abort_ready", ready, 1'b1);
    check1("abort_busy", busy, 1'b0);
    check1("abort_done", done, 1'b0);
    check16("abort_product", product, 16'h0000);
    repeat (8) @(negedge clk);
    check_int("abort_no_done", done_cnt - base, 0);
    directed("u_12_34", 1'b0, 8'h12, 8'h34, 16'h03A8);

    // Random sweep, checked cycle by cycle by the compare process
    for (int i = 0; i < 10000; i++) begin
      wait_ready();
      issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), acc_c);
    end
    wait_ready();
    check_int("queue_drained", exp_q.size(), 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
